emesh_rr_arbiter: RTL and testbench

//  N-way round-robin arbiter that shares one emesh packet channel (write/datamode/ctrlmode/dstaddr/data/srcaddr, PW-bit packed)

---
 rtl/emesh_pkg.sv | 24 ++
 rtl/emesh_rr_arbiter_if.sv | 26 ++
 rtl/emesh_rr_pick.sv | 32 +++
 rtl/emesh_rr_arbiter.sv | 91 +++++++++
 tb/tb_emesh_rr_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/emesh_pkg.sv
// Shared emesh definitions: packet width, packet field offsets and the
// output-stage state type used by emesh muxes and arbiters.
package emesh_pkg;

  localparam int EMESH_PW_32 = 104;

  localparam int WRITE_BIT    = 0;
  localparam int DATAMODE_LSB = 1;
  localparam int DATAMODE_MSB = 2;
  localparam int CTRLMODE_LSB = 3;
  localparam int CTRLMODE_MSB = 7;
  localparam int DSTADDR_LSB  = 8;
  localparam int DSTADDR_MSB  = 39;
  localparam int DATA_LSB     = 40;
  localparam int DATA_MSB     = 71;
  localparam int SRCADDR_LSB  = 72;
  localparam int SRCADDR_MSB  = 103;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } emesh_out_state_t;

endpackage

// File: rtl/emesh_rr_arbiter_if.sv
// Request and output channel bundle of the emesh round-robin arbiter.
// The arbiter uses the slave modport; requesters/downstream use master.
interface emesh_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int PW = 104
) ();

  logic [N-1:0]         access_in;
  logic [N*PW-1:0]      packet_in;
  logic [N-1:0]         wait_out;
  logic                 access_out;
  logic [PW-1:0]        packet_out;
  logic                 wait_in;
  logic [$clog2(N)-1:0] grant_id;

  modport slave (
    input  access_in, packet_in, wait_in,
    output wait_out, access_out, packet_out, grant_id
  );

  modport master (
    output access_in, packet_in, wait_in,
    input  wait_out, access_out, packet_out, grant_id
  );

endinterface

// File: rtl/emesh_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// priority-encode the lowest set bit, then add ptr back modulo N.
module emesh_rr_pick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W-1:0]   offset;
  logic [W:0]     sum;

  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[N-1:0];
    valid   = |req;
    offset  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) offset = W'(k);
    end
    // ptr < N and offset < N, so a single subtraction wraps the sum
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    winner = sum[W-1:0];
  end

endmodule

// File: rtl/emesh_rr_arbiter.sv
// N-way round-robin arbiter onto one registered emesh packet channel.
// Optional per-requester write/read transfer counters with EMESH_ARB_STATS_EN.
module emesh_rr_arbiter
  import emesh_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = EMESH_PW_32
) (
  input  logic               clk,
  input  logic               reset,
  emesh_rr_arbiter_if.slave  bus
`ifdef EMESH_ARB_STATS_EN
  ,
  input  logic               stat_clear,
  output logic [N*32-1:0]    stat_wr_cnt,
  output logic [N*32-1:0]    stat_rd_cnt
`endif
);

  localparam int W = $clog2(N);

  emesh_out_state_t state;
  emesh_out_state_t state_nxt;
  logic [W-1:0]     ptr;
  logic [W-1:0]     winner;
  logic             pick_valid;
  logic             load;
  logic             grant;

  emesh_rr_pick #(.N(N)) u_pick (
    .req    (bus.access_in),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (winner)
  );

  // The output register can take a packet when empty or when it drains this cycle
  always_comb begin
    load  = (state == EMPTY) || !bus.wait_in;
    grant = load && pick_valid;
    bus.wait_out = '1;
    if (!reset && grant) bus.wait_out[winner] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (!bus.wait_in && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.access_out = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= EMPTY;
      ptr            <= '0;
      bus.packet_out <= '0;
      bus.grant_id   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        bus.packet_out <= bus.packet_in[winner*PW +: PW];
        bus.grant_id   <= winner;
        ptr            <= (winner == W'(N - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

`ifdef EMESH_ARB_STATS_EN
  // Clear wins over a coincident transfer so software sees a clean zero
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (grant && (winner == W'(i))) begin
          if (bus.packet_in[i*PW + WRITE_BIT])
            stat_wr_cnt[i*32 +: 32] <= stat_wr_cnt[i*32 +: 32] + 32'd1;
          else
            stat_rd_cnt[i*32 +: 32] <= stat_rd_cnt[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_emesh_rr_arbiter.sv
// Directed bench for emesh_rr_arbiter (N=4, PW=104) with hand-computed expectations.
// Stats checks are included when EMESH_ARB_STATS_EN is defined.
module tb_emesh_rr_arbiter;

  localparam int N  = 4;
  localparam int PW = 104;

  localparam logic [PW-1:0] P0 = {8'hA0, 88'h0, 8'h01};
  localparam logic [PW-1:0] P1 = {8'hB1, 88'h0, 8'h10};
  localparam logic [PW-1:0] P2 = {8'hC2, 88'h0, 8'h21};
  localparam logic [PW-1:0] P3 = {8'hD3, 88'h0, 8'h30};

  logic clk;
  logic reset;
  logic [PW-1:0] pkt [N];
  int vectors;
  int miscompares;

  emesh_rr_arbiter_if #(.N(N), .PW(PW)) bus ();

`ifdef EMESH_ARB_STATS_EN
  logic              stat_clear;
  logic [N*32-1:0]   stat_wr_cnt;
  logic [N*32-1:0]   stat_rd_cnt;
`endif

  emesh_rr_arbiter #(.N(N), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef EMESH_ARB_STATS_EN
    ,
    .stat_clear  (stat_clear),
    .stat_wr_cnt (stat_wr_cnt),
    .stat_rd_cnt (stat_rd_cnt)
`endif
  );

  assign bus.packet_in = {pkt[3], pkt[2], pkt[1], pkt[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs settle by #1
  task automatic applyStimulus(input logic rst, input logic [N-1:0] acc, input logic win);
    @(negedge clk);
    reset        = rst;
    bus.access_in = acc;
    bus.wait_in  = win;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    applyStimulus(1'b1, '0, 1'b0);
    tick();
  endtask

  initial begin
    logic [1:0] rot_seq [8];
    logic [PW-1:0] seq_pkt [4];
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.access_in = '0;
    bus.wait_in = 1'b0;
    pkt[0] = P0; pkt[1] = P1; pkt[2] = P2; pkt[3] = P3;
`ifdef EMESH_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    rot_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    seq_pkt = '{{8'h0A, 96'h0}, {8'h0B, 96'h0}, {8'h0C, 96'h0}, {8'h0D, 96'h0}};

    $display("[TB] reset with all requesters active");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'b1111, 1'b0);
      checkOutput("rst_wait_out", 128'(bus.wait_out), 128'(4'b1111));
      tick();
      checkOutput("rst_access_out", 128'(bus.access_out), 128'(1'b0));
    end
    checkOutput("rst_packet_out", 128'(bus.packet_out), 128'(0));
    checkOutput("rst_grant_id", 128'(bus.grant_id), 128'(0));
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("first_wait_out", 128'(bus.wait_out), 128'(4'b1110));
    tick();
    checkOutput("first_access_out", 128'(bus.access_out), 128'(1'b1));
    checkOutput("first_grant_id", 128'(bus.grant_id), 128'(0));
    checkOutput("first_packet_out", 128'(bus.packet_out), 128'(P0));

    $display("[TB] rotation with all requesters");
    resetPulse();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      tick();
      checkOutput("rot_grant_id", 128'(bus.grant_id), 128'(rot_seq[k]));
      checkOutput("rot_packet_out", 128'(bus.packet_out), 128'(pkt[rot_seq[k]]));
      checkOutput("rot_access_out", 128'(bus.access_out), 128'(1'b1));
    end

    $display("[TB] lone requester 2 streaming");
    resetPulse();
    for (int k = 0; k < 4; k++) begin
      pkt[2] = seq_pkt[k];
      applyStimulus(1'b0, 4'b0100, 1'b0);
      checkOutput("lone_wait_out", 128'(bus.wait_out), 128'(4'b1011));
      tick();
      checkOutput("lone_packet_out", 128'(bus.packet_out), 128'(seq_pkt[k]));
      checkOutput("lone_grant_id", 128'(bus.grant_id), 128'(2));
    end
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick();
    checkOutput("lone_drain_access_out", 128'(bus.access_out), 128'(1'b0));
    pkt[2] = P2;

    $display("[TB] backpressure while full");
    resetPulse();
    applyStimulus(1'b0, 4'b0001, 1'b0);
    tick();
    checkOutput("bp_fill_packet_out", 128'(bus.packet_out), 128'(P0));
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b1010, 1'b1);
      checkOutput("bp_wait_out", 128'(bus.wait_out), 128'(4'b1111));
      tick();
      checkOutput("bp_hold_packet_out", 128'(bus.packet_out), 128'(P0));
      checkOutput("bp_hold_access_out", 128'(bus.access_out), 128'(1'b1));
      checkOutput("bp_hold_grant_id", 128'(bus.grant_id), 128'(0));
    end
    applyStimulus(1'b0, 4'b1010, 1'b0);
    checkOutput("bp_rel1_wait_out", 128'(bus.wait_out), 128'(4'b1101));
    tick();
    checkOutput("bp_rel1_grant_id", 128'(bus.grant_id), 128'(1));
    checkOutput("bp_rel1_packet_out", 128'(bus.packet_out), 128'(P1));
    applyStimulus(1'b0, 4'b1010, 1'b0);
    checkOutput("bp_rel2_wait_out", 128'(bus.wait_out), 128'(4'b0111));
    tick();
    checkOutput("bp_rel2_grant_id", 128'(bus.grant_id), 128'(3));
    checkOutput("bp_rel2_packet_out", 128'(bus.packet_out), 128'(P3));

    $display("[TB] reset while full and stalled");
    resetPulse();
    applyStimulus(1'b0, 4'b0010, 1'b0);
    tick();
    checkOutput("mid_fill_grant_id", 128'(bus.grant_id), 128'(1));
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkOutput("mid_hold_access_out", 128'(bus.access_out), 128'(1'b1));
    applyStimulus(1'b1, 4'b0010, 1'b1);
    checkOutput("mid_rst_wait_out", 128'(bus.wait_out), 128'(4'b1111));
    tick();
    checkOutput("mid_rst_access_out", 128'(bus.access_out), 128'(1'b0));
    checkOutput("mid_rst_packet_out", 128'(bus.packet_out), 128'(0));
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick();
    checkOutput("mid_idle_access_out", 128'(bus.access_out), 128'(1'b0));
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("mid_ptr0_wait_out", 128'(bus.wait_out), 128'(4'b1110));
    tick();
    checkOutput("mid_ptr0_grant_id", 128'(bus.grant_id), 128'(0));

`ifdef EMESH_ARB_STATS_EN
    $display("[TB] transfer statistics");
    resetPulse();
    for (int k = 0; k < 5; k++) begin
      pkt[0] = (k < 3) ? (P0 | PW'(1)) : (P0 & ~PW'(1));
      applyStimulus(1'b0, 4'b0001, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick();
    checkOutput("stat_wr0", 128'(stat_wr_cnt[31:0]), 128'(3));
    checkOutput("stat_rd0", 128'(stat_rd_cnt[31:0]), 128'(2));
    checkOutput("stat_wr1", 128'(stat_wr_cnt[63:32]), 128'(0));
    pkt[0] = P0;
    applyStimulus(1'b0, 4'b0001, 1'b0);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    checkOutput("stat_clr_wr0", 128'(stat_wr_cnt[31:0]), 128'(0));
    checkOutput("stat_clr_rd0", 128'(stat_rd_cnt[31:0]), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
